// File: rtl/exec_datapath.sv
// exec_datapath: word RAM, ARM mode-1 barrel shifter and 16-opcode ALU with NZCV register
module exec_datapath #(
  parameter int    ADDR_W    = 18,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_data,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              exec_en,
  input  logic [3:0]        opcode,
  input  logic [31:0]       operand1,
  input  logic [31:0]       shift_in,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_imm,
  input  logic              use_rs,
  input  logic [7:0]        rs_value,
  input  logic              is_imm32,
  input  logic              set_flags,
  output logic [31:0]       result,
  output logic [3:0]        flags,
  output logic              result_valid,
  output logic              writes_rd
);
  localparam int IW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] ridx, widx;
  assign ridx = IW'(fetch_addr % DEPTH);
  assign widx = IW'(load_addr % DEPTH);
  always_ff @(posedge clk)
    if (load_we) mem[widx] <= load_data;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) fetch_data <= '0;
    else if (fetch_en) fetch_data <= mem[ridx];
  logic        c_in, sh_c;
  logic [7:0]  amt;
  logic [4:0]  rot, rimm;
  logic [32:0] lsl, lsr, asr;
  logic [31:0] ror, imm, op2;
  assign c_in = flags[1];
  always_comb begin
    amt  = use_rs ? rs_value
         : (shift_imm == 5'd0 && shift_type inside {2'b01, 2'b10}) ? 8'd32 : {3'b0, shift_imm};
    rot  = use_rs ? rs_value[4:0] : shift_imm;
    rimm = {shift_imm[3:0], 1'b0};
    lsl  = {1'b0, shift_in} << amt;
    lsr  = {shift_in, 1'b0} >> amt;
    asr  = 33'($signed({shift_in, 1'b0}) >>> amt);
    ror  = (shift_in >> rot) | (shift_in << (6'd32 - {1'b0, rot}));
    imm  = ({24'b0, shift_in[7:0]} >> rimm) | ({24'b0, shift_in[7:0]} << (6'd32 - {1'b0, rimm}));
    op2  = shift_in;
    sh_c = c_in;
    if (is_imm32) begin
      op2  = imm;
      sh_c = (rimm == 5'd0) ? c_in : imm[31];
    end else if (shift_type == 2'b11) begin
      if (!use_rs && rot == 5'd0) {op2, sh_c} = {c_in, shift_in};
      else if (!(use_rs && rs_value == 8'd0)) {op2, sh_c} = {ror, ror[31]};
    end else if (amt != 8'd0) begin
      if (shift_type == 2'b00) {sh_c, op2} = lsl;
      else if (shift_type == 2'b01) {op2, sh_c} = lsr;
      else {op2, sh_c} = asr;
    end
  end
  logic        rev, inv, arith, cin, ovf;
  logic [31:0] a, b, logic_res, res;
  logic [32:0] sum;
  always_comb begin
    rev   = opcode inside {4'h3, 4'h7};
    inv   = opcode inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA};
    arith = opcode inside {[4'h2:4'h7], 4'hA, 4'hB};
    cin   = (opcode inside {4'h2, 4'h3, 4'hA}) ? 1'b1 : (opcode inside {[4'h5:4'h7]}) ? c_in : 1'b0;
    a     = rev ? op2 : operand1;
    b     = inv ? ~(rev ? operand1 : op2) : (rev ? operand1 : op2);
    sum   = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    ovf   = (a[31] == b[31]) && (sum[31] != a[31]);
    logic_res = (opcode inside {4'h0, 4'h8}) ? operand1 & op2
              : (opcode inside {4'h1, 4'h9}) ? operand1 ^ op2
              : (opcode == 4'hC) ? operand1 | op2
              : (opcode == 4'hD) ? op2
              : (opcode == 4'hE) ? operand1 & ~op2
              : ~op2;
    res = arith ? sum[31:0] : logic_res;
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      writes_rd    <= 1'b0;
    end else begin
      result_valid <= exec_en;
      if (exec_en) begin
        result    <= res;
        writes_rd <= opcode[3:2] != 2'b10;
      end
      if (exec_en && set_flags)
        flags <= {res[31], res == 32'd0, arith ? sum[32] : sh_c, arith ? ovf : flags[0]};
    end
endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: directed vectors; ALU results checked by a queue-based scoreboard monitor.
module tb_exec_datapath;
    logic        clk = 1'b0, n_reset = 1'b0;
    logic        fetch_en = 1'b0, load_we = 1'b0, exec_en = 1'b0;
    logic [17:0] fetch_addr = '0, load_addr = '0;
    logic [31:0] fetch_data, load_data = '0, operand1 = '0, shift_in = '0, result;
    logic [3:0]  opcode = '0, flags;
    logic [1:0]  shift_type = '0;
    logic [4:0]  shift_imm = '0;
    logic        use_rs = 1'b0, is_imm32 = 1'b0, set_flags = 1'b0, result_valid, writes_rd;
    logic [7:0]  rs_value = '0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic        w;
        int          id;
    } exp_t;

    exp_t q[$];
    int   total = 0, passed = 0, n_ops = 0;

    exec_datapath dut (
        .clk(clk), .n_reset(n_reset),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .exec_en(exec_en), .opcode(opcode), .operand1(operand1), .shift_in(shift_in),
        .shift_type(shift_type), .shift_imm(shift_imm), .use_rs(use_rs), .rs_value(rs_value),
        .is_imm32(is_imm32), .set_flags(set_flags),
        .result(result), .flags(flags), .result_valid(result_valid), .writes_rd(writes_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (n_reset && result_valid) begin
            if (q.size() == 0) chk("unexpected result_valid", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk($sformatf("op%0d result", e.id), result, e.r);
                chk($sformatf("op%0d flags", e.id), {28'b0, flags}, {28'b0, e.f});
                chk($sformatf("op%0d writes_rd", e.id), {31'b0, writes_rd}, {31'b0, e.w});
            end
        end
    end

    task automatic exec(input logic [3:0] op, input logic [31:0] o1, x, input logic [1:0] st,
                        input logic [4:0] si, input logic ur, input logic [7:0] rs,
                        input logic i32, s, input logic [31:0] er, input logic [3:0] ef, input logic ew);
        exp_t e;
        opcode = op; operand1 = o1; shift_in = x; shift_type = st; shift_imm = si;
        use_rs = ur; rs_value = rs; is_imm32 = i32; set_flags = s; exec_en = 1'b1;
        n_ops++;
        e.r = er; e.f = ef; e.w = ew; e.id = n_ops;
        q.push_back(e);
        @(posedge clk);
        #1 exec_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #1 chk("scoreboard drained", q.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset fetch_data", fetch_data, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'b0, flags}, 32'd0);
        chk("reset result_valid", {31'b0, result_valid}, 32'd0);
        chk("reset writes_rd", {31'b0, writes_rd}, 32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1 load_we = 1'b1; load_addr = 18'd5; load_data = 32'hE3A01005;
        @(posedge clk);
        #1 load_we = 1'b0; fetch_en = 1'b1; fetch_addr = 18'd5;
        @(posedge clk);
        #1 fetch_en = 1'b0;
        chk("fetch preload", fetch_data, 32'hE3A01005);
        load_we = 1'b1; load_data = 32'h12345678; fetch_en = 1'b1;
        @(posedge clk);
        #1 load_we = 1'b0; fetch_en = 1'b0;
        chk("fetch read-first", fetch_data, 32'hE3A01005);
        fetch_addr = 18'd6;
        @(posedge clk);
        #1 chk("fetch hold", fetch_data, 32'hE3A01005);
        fetch_en = 1'b1; fetch_addr = 18'd1029;
        @(posedge clk);
        #1 fetch_en = 1'b0;
        chk("fetch alias", fetch_data, 32'h12345678);
        //    op     operand1      shift_in      st  si  rs rsv    i32 S  result        NZCV  wr
        exec(4'h4, 32'h7FFFFFFF, 32'h1,        0, 0,  0, 0,     0, 1, 32'h80000000, 4'h9, 1);
        exec(4'h2, 32'd5,        32'd5,        0, 0,  0, 0,     0, 1, 32'd0,        4'h6, 1);
        exec(4'hA, 32'd5,        32'd5,        0, 0,  0, 0,     0, 1, 32'd0,        4'h6, 0);
        exec(4'hD, 32'd0,        32'hFF,       0, 4,  0, 0,     1, 1, 32'hFF000000, 4'hA, 1);
        exec(4'h5, 32'd1,        32'd1,        0, 0,  0, 0,     0, 1, 32'd3,        4'h0, 1);
        exec(4'hD, 32'd0,        32'h80000000, 1, 0,  0, 0,     0, 0, 32'd0,        4'h0, 1);
        exec(4'hD, 32'd0,        32'h80000000, 1, 0,  0, 0,     0, 1, 32'd0,        4'h6, 1);
        exec(4'hD, 32'd0,        32'h2,        3, 0,  0, 0,     0, 1, 32'h80000001, 4'h8, 1);
        exec(4'hD, 32'd0,        32'hFFFFFFFF, 0, 0,  1, 33,    0, 1, 32'd0,        4'h4, 1);
        exec(4'hD, 32'd0,        32'h1,        0, 0,  1, 32,    0, 1, 32'd0,        4'h6, 1);
        exec(4'hD, 32'd0,        32'h80000000, 2, 0,  0, 0,     0, 1, 32'hFFFFFFFF, 4'hA, 1);
        exec(4'h6, 32'd5,        32'd3,        0, 0,  0, 0,     0, 1, 32'd2,        4'h2, 1);
        exec(4'h3, 32'd3,        32'd1,        0, 0,  0, 0,     0, 1, 32'hFFFFFFFE, 4'h8, 1);
        exec(4'h6, 32'd5,        32'd3,        0, 0,  0, 0,     0, 1, 32'd1,        4'h2, 1);
        exec(4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 1, 8,  0, 0,     0, 1, 32'hF00FF00F, 4'h8, 1);
        exec(4'h9, 32'hF0F0F0F0, 32'hFF00FF00, 1, 8,  0, 0,     0, 1, 32'hF00FF00F, 4'h8, 0);
        exec(4'hE, 32'hFFFF,     32'h0F0F,     0, 4,  0, 0,     0, 0, 32'h0F0F,     4'h8, 1);
        exec(4'hF, 32'd0,        32'h80000001, 3, 0,  1, 8'h20, 0, 1, 32'h7FFFFFFE, 4'h2, 1);
        exec(4'hD, 32'd0,        32'h12345678, 1, 0,  1, 0,     0, 1, 32'h12345678, 4'h2, 1);
        exec(4'hB, 32'hFFFFFFFF, 32'd1,        0, 0,  0, 0,     0, 1, 32'd0,        4'h6, 0);
        exec(4'h7, 32'd4,        32'd10,       0, 0,  0, 0,     0, 1, 32'd6,        4'h2, 1);
        exec(4'h2, 32'h80000000, 32'd1,        0, 0,  0, 0,     0, 1, 32'h7FFFFFFF, 4'h3, 1);
        exec(4'hD, 32'd0,        32'hF0000000, 0, 4,  0, 0,     0, 1, 32'd0,        4'h7, 1);
        exec(4'hD, 32'd0,        32'h80000010, 2, 4,  0, 0,     0, 1, 32'hF8000001, 4'h9, 1);
        exec(4'hD, 32'd0,        32'hAB,       3, 8,  0, 0,     0, 1, 32'hAB000000, 4'hB, 1);
        exec(4'hD, 32'd0,        32'h7FFFFFFF, 2, 0,  1, 40,    0, 1, 32'd0,        4'h5, 1);
        exec(4'hD, 32'd0,        32'h80000000, 1, 0,  1, 32,    0, 1, 32'd0,        4'h7, 1);
        drain();
        opcode = 4'hB; operand1 = 32'hFFFFFFFF; shift_in = 32'd1; shift_type = 2'b00; shift_imm = 5'd0;
        use_rs = 1'b0; is_imm32 = 1'b0; set_flags = 1'b1; exec_en = 1'b1;
        @(posedge clk);
        #1 exec_en = 1'b0;
        chk("pre-reset result_valid", {31'b0, result_valid}, 32'd1);
        chk("pre-reset flags", {28'b0, flags}, 32'h6);
        n_reset = 1'b0;
        #1;
        chk("async reset result_valid", {31'b0, result_valid}, 32'd0);
        chk("async reset flags", {28'b0, flags}, 32'd0);
        chk("async reset result", result, 32'd0);
        chk("async reset fetch_data", fetch_data, 32'd0);
        @(posedge clk);
        #1 n_reset = 1'b1;
        exec(4'h5, 32'd1, 32'd1, 0, 0, 0, 0, 0, 1, 32'd2, 4'h0, 1);
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
